// File: rtl/gen_step_engine.sv
// Game of Life generation sequencer.
// Walks the field RAM row by row, computes each cell's next state from the
// combinational cell/neighbour read-back, and writes results back in place.
// Two row buffers hold computed rows until the row below has been read, so
// every read still sees previous-generation data.
module gen_step_engine #(
    parameter int FIELD_W   = 30,
    parameter int FIELD_H   = 50,
    parameter int GEN_CNT_W = 16,
    // A one-row or one-column field still gets a 1-bit address bus.
    localparam int X_ADR_SIZE     = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
    localparam int Y_ADR_SIZE     = (FIELD_H > 1) ? $clog2(FIELD_H) : 1,
    localparam int NEIGHBOURS_CNT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [GEN_CNT_W-1:0]      o_gen_cnt,
    output logic [X_ADR_SIZE-1:0]     o_cell_x_adr,
    output logic [Y_ADR_SIZE-1:0]     o_cell_y_adr,
    output logic                      o_w_en,
    output logic                      o_new_cell_state,
    input  logic                      i_cell_state,
    input  logic [NEIGHBOURS_CNT-1:0] i_nbrs
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    state_t                 state_reg, state_next;
    logic [X_ADR_SIZE-1:0]  x_reg, x_next;
    logic [Y_ADR_SIZE-1:0]  y_reg, y_next;
    logic [FIELD_W-1:0]     cur_buf_reg, cur_buf_next;
    logic [FIELD_W-1:0]     prev_buf_reg, prev_buf_next;
    logic [GEN_CNT_W-1:0]   gen_cnt_reg, gen_cnt_next;

    logic [3:0]             nbr_cnt;
    logic                   next_cell;
    logic                   x_at_last;

    // Live-neighbour count, one adder stage per neighbour bit.
    logic [3:0] nbr_sum [NEIGHBOURS_CNT+1];
    assign nbr_sum[0] = 4'd0;
    generate
        for (genvar gi = 0; gi < NEIGHBOURS_CNT; gi++) begin : g_popcount
            assign nbr_sum[gi+1] = nbr_sum[gi] + {3'd0, i_nbrs[gi]};
        end
    endgenerate
    assign nbr_cnt = nbr_sum[NEIGHBOURS_CNT];

    // B3/S23: a live cell survives on 2 or 3 neighbours, a dead one is born on 3.
    assign next_cell = i_cell_state ? ((nbr_cnt == 4'd2) || (nbr_cnt == 4'd3))
                                    : (nbr_cnt == 4'd3);

    assign x_at_last = (x_reg == X_LAST);

    // State, scan position, row buffers and generation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            cur_buf_reg  <= '0;
            prev_buf_reg <= '0;
            gen_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            cur_buf_reg  <= cur_buf_next;
            prev_buf_reg <= prev_buf_next;
            gen_cnt_reg  <= gen_cnt_next;
        end
    end

    // Next-state sequencing and RAM master outputs.
    always_comb begin
        state_next       = state_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        cur_buf_next     = cur_buf_reg;
        prev_buf_next    = prev_buf_reg;
        gen_cnt_next     = gen_cnt_reg;
        o_busy           = 1'b0;
        o_done           = 1'b0;
        o_cell_x_adr     = '0;
        o_cell_y_adr     = '0;
        o_w_en           = 1'b0;
        o_new_cell_state = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = READ;
                    x_next     = '0;
                    y_next     = '0;
                end
            end

            READ: begin
                o_busy               = 1'b1;
                o_cell_x_adr         = x_reg;
                o_cell_y_adr         = y_reg;
                cur_buf_next[x_reg]  = next_cell;
                if (x_at_last) begin
                    x_next = '0;
                    if (y_reg == '0) begin
                        // First row has nothing above it to write yet; park it
                        // (including the cell computed this cycle) in prev_buf.
                        prev_buf_next = cur_buf_next;
                        if (FIELD_H == 1) begin
                            state_next = FLUSH;
                        end else begin
                            y_next = Y_ADR_SIZE'(1);
                        end
                    end else begin
                        state_next = WRITE;
                    end
                end else begin
                    x_next = x_reg + X_ADR_SIZE'(1);
                end
            end

            WRITE: begin
                // Row y has been read, so row y-1 is no longer needed as input.
                o_busy           = 1'b1;
                o_cell_x_adr     = x_reg;
                o_cell_y_adr     = y_reg - Y_ADR_SIZE'(1);
                o_w_en           = 1'b1;
                o_new_cell_state = prev_buf_reg[x_reg];
                if (x_at_last) begin
                    x_next        = '0;
                    prev_buf_next = cur_buf_reg;
                    if (y_reg == Y_LAST) begin
                        state_next = FLUSH;
                    end else begin
                        y_next     = y_reg + Y_ADR_SIZE'(1);
                        state_next = READ;
                    end
                end else begin
                    x_next = x_reg + X_ADR_SIZE'(1);
                end
            end

            FLUSH: begin
                // Last row has no row below it; write it out unconditionally.
                o_busy           = 1'b1;
                o_cell_x_adr     = x_reg;
                o_cell_y_adr     = Y_LAST;
                o_w_en           = 1'b1;
                o_new_cell_state = prev_buf_reg[x_reg];
                if (x_at_last) begin
                    x_next     = '0;
                    y_next     = '0;
                    state_next = DONE;
                end else begin
                    x_next = x_reg + X_ADR_SIZE'(1);
                end
            end

            DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                gen_cnt_next = gen_cnt_reg + GEN_CNT_W'(1);
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_gen_cnt = gen_cnt_reg;

endmodule

// File: tb/tb_gen_step_engine.sv
// Directed bench for gen_step_engine on a 5x5 field with a behavioural field
// RAM. Every expected write (address + data) is queued when a step is started
// and popped as the engine writes.
module tb_gen_step_engine;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int GW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [GW-1:0] gen_cnt;
    logic [XW-1:0] cell_x;
    logic [YW-1:0] cell_y;
    logic          w_en;
    logic          new_state;
    logic          cell_state;
    logic [7:0]    nbrs;

    logic [H*W-1:0] fld;
    logic [H*W-1:0] preset;
    logic           preset_en;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       v;
    } wr_t;

    wr_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt, done_cnt, done_at, wen_cnt, max_x, max_y;

    gen_step_engine #(
        .FIELD_W   (W),
        .FIELD_H   (H),
        .GEN_CNT_W (GW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (start),
        .o_busy           (busy),
        .o_done           (done),
        .o_gen_cnt        (gen_cnt),
        .o_cell_x_adr     (cell_x),
        .o_cell_y_adr     (cell_y),
        .o_w_en           (w_en),
        .o_new_cell_state (new_state),
        .i_cell_state     (cell_state),
        .i_nbrs           (nbrs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field RAM model: shares rst, bench preload port, engine write port.
    always @(posedge clk or posedge rst) begin
        if (rst)            fld <= '0;
        else if (preset_en) fld <= preset;
        else if (w_en && int'(cell_x) < W && int'(cell_y) < H)
            fld[int'(cell_y)*W + int'(cell_x)] <= new_state;
    end

    // Combinational read port: cell plus its 8 neighbours, 0 off-field.
    always_comb begin
        int ax, ay, k;
        ax = int'(cell_x);
        ay = int'(cell_y);
        k  = 0;
        cell_state = 1'b0;
        nbrs       = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
                    if (ax+dx >= 0 && ax+dx < W && ay+dy >= 0 && ay+dy < H)
                        nbrs[k] = fld[(ay+dy)*W + ax + dx];
                    k++;
                end
            end
        end
        if (ax < W && ay < H) cell_state = fld[ay*W + ax];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference Life step on a snapshot of the field.
    function automatic logic [H*W-1:0] next_gen(input logic [H*W-1:0] f);
        logic [H*W-1:0] r;
        int n;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (!(dx == 0 && dy == 0) && x+dx >= 0 && x+dx < W && y+dy >= 0 && y+dy < H)
                            n += int'(f[(y+dy)*W + x + dx]);
                r[y*W+x] = f[y*W+x] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return r;
    endfunction

    // Write monitor: one line per engine write, compared against the queue.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (busy) begin
                busy_cnt++;
                if (int'(cell_x) > max_x) max_x = int'(cell_x);
                if (int'(cell_y) > max_y) max_y = int'(cell_y);
            end
            if (done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (w_en) begin
                wen_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("write x=%0d y=%0d v=%0d (exp x=%0d y=%0d v=%0d)",
                             cell_x, cell_y, new_state, e.x, e.y, e.v);
                    check("write", 32'({8'(cell_x), 8'(cell_y), new_state}), 32'(e));
                end
            end
        end
    end

    task automatic load(input logic [H*W-1:0] v);
        @(negedge clk);
        preset    = v;
        preset_en = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
    endtask

    task automatic push_expected();
        logic [H*W-1:0] nxt;
        nxt = next_gen(fld);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                sb.push_back('{x: 8'(x), y: 8'(y), v: nxt[y*W+x]});
    endtask

    // One full step; optionally pulses start while busy.
    task automatic run_step(input string tag, input bit pulse_mid);
        busy_cnt = 0; done_cnt = 0; done_at = 0; wen_cnt = 0; max_x = 0; max_y = 0;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (done_cnt != 0) break;
            #2 start = pulse_mid && (i % 7 == 3);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
        $display("step %s: busy=%0d done_at=%0d wen=%0d gen=%0d", tag, busy_cnt, done_at, wen_cnt, gen_cnt);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(2*W*H + 1));
        check({tag, "_done_at"}, 32'(done_at), 32'(2*W*H + 1));
        check({tag, "_wen_cycles"}, 32'(wen_cnt), 32'(W*H));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    localparam logic [H*W-1:0] BLINK_H = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
    localparam logic [H*W-1:0] BLINK_V = (25'd1 << 7)  | (25'd1 << 12) | (25'd1 << 17);
    localparam logic [H*W-1:0] BLOCK   = (25'd1 << 6)  | (25'd1 << 7)  | (25'd1 << 11) | (25'd1 << 12);

    initial begin
        rst = 1'b1; start = 1'b0; preset = '0; preset_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({busy, done, w_en, new_state, cell_x, cell_y}), 32'd0);
        check("rst_gen", 32'(gen_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'({busy, done, w_en, cell_x, cell_y}), 32'd0);

        // Blinker oscillates with period 2.
        load(BLINK_H);
        run_step("blink1", 1'b0);
        check("blink1_field", 32'(fld), 32'(BLINK_V));
        check("blink1_gen", 32'(gen_cnt), 32'd1);
        run_step("blink2", 1'b0);
        check("blink2_field", 32'(fld), 32'(BLINK_H));
        check("blink2_gen", 32'(gen_cnt), 32'd2);

        // Block is a still life.
        load(BLOCK);
        run_step("block", 1'b0);
        check("block_field", 32'(fld), 32'(BLOCK));

        // Lone corner cell dies; scan stays inside the field.
        load(25'd1);
        run_step("corner", 1'b0);
        check("corner_field", 32'(fld), 32'd0);
        check("corner_max_x", 32'(max_x), 32'(W-1));
        check("corner_max_y", 32'(max_y), 32'(H-1));

        // Start pulses while busy are ignored.
        load(BLINK_H);
        run_step("pulse", 1'b1);
        check("pulse_field", 32'(fld), 32'(BLINK_V));
        check("pulse_gen", 32'(gen_cnt), 32'd5);

        // Reset during WRITE of row 1.
        load(BLINK_H);
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #2;
                if (w_en && cell_y == YW'(1)) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("mid_write_row1_reached", 32'(hit), 32'd1);
        end
        #1 rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_outputs", 32'({busy, done, w_en, new_state, cell_x, cell_y}), 32'd0);
        check("midrst_gen", 32'(gen_cnt), 32'd0);
        check("midrst_field", 32'(fld), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load(BLINK_H);
        run_step("after_rst", 1'b0);
        check("after_rst_field", 32'(fld), 32'(BLINK_V));
        check("after_rst_gen", 32'(gen_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
